stopwatch_core: RTL and testbench
=================================

Name: stopwatch_core

Overview:
- Consumes the 1 Hz square wave produced by the frequency divider and runs an mm:ss stopwatch in BCD.
- Provides start/stop/clear control and drives a 4-digit multiplexed 7-segment display.
- Sits directly downstream of the divider.
- Runs entirely on the 50 MHz board clock; the 1 Hz signal is treated as data: synchronised, then edge-detected.

Parameters:
REFRESH_DIV, 50000, clk_in cycles per display digit slot (1 kHz per digit at 50 MHz); legal range 2..2^20
SEG_ACTIVE_LOW, 1, 1 = seg and an outputs active-low; 0 = active-high

Ports:
clk_in  input  1  50 MHz system clock
rst  input  1  asynchronous, active-high reset
tick_in  input  1  1 Hz square wave from divider; asynchronous to logic, sampled on clk_in
start_stop  input  1  single-cycle pulse; toggles run/pause
clear  input  1  single-cycle pulse; stops and zeroes the stopwatch
running  output  1  high while in RUN
sec_ones  output  4  BCD 0..9
sec_tens  output  4  BCD 0..5
min_ones  output  4  BCD 0..9
min_tens  output  4  BCD 0..5
rollover  output  1  one-cycle pulse on 59:59 -> 00:00
seg  output  7  segments {g,f,e,d,c,b,a}
an  output  4  digit enables; an[0] = sec_ones … an[3] = min_tens

Behaviour:
- Reset is one clock and asynchronous, active-high. rst asserted forces:
  - state IDLE, all digits 0, running=0, rollover=0
  - synchroniser and edge flops 0
  - refresh counter 0, digit index 0
  - an selects digit 0 (an=4'b1110 when active-low); seg shows "0" (7'b1000000 when active-low)
- Tick path:
  - tick_in passes through a 2-flop synchroniser (s1, s2), then an edge register (s2_d).
  - tick = s2 & ~s2_d.
  - If tick_in is first sampled high at edge k, tick is high during the cycle after edge k+1, and the count updates at edge k+2.
  - Exactly one tick per tick_in rising edge. A level held high does not retrigger.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE --start_stop--> RUN
  - RUN --start_stop--> PAUSE
  - PAUSE --start_stop--> RUN
  - any state --clear--> IDLE, with digits zeroed on the same edge.
  - clear and start_stop together: clear wins, next state IDLE.
- Counting: only in RUN, only on tick.
  - sec_ones increments; 9->0 carries to sec_tens.
  - sec_tens 5->0 carries to min_ones; min_ones 9->0 carries to min_tens.
  - min_tens 5->0 means full rollover: 59:59 -> 00:00, rollover high for exactly that one cycle, state stays RUN.
- Simultaneous events:
  - tick with clear: clear wins, digits 0, no increment.
  - tick with start_stop in RUN: increment applied, then PAUSE.
  - tick with start_stop in PAUSE: no increment, then RUN.
  - tick in IDLE or PAUSE: ignored, no backlog kept.
- Outputs running and all digits are registered and change only at the clock edge that applies the event.
- Display multiplexer:
  - Refresh counter counts 0..REFRESH_DIV-1; on wrap, the 2-bit digit index increments (3->0).
  - seg and an are registered from the current index and digits, so they lag index and digit changes by one cycle.
  - Decode uses standard 0-9 glyphs. Values 10-15 cannot occur; if forced, seg is blank (all off).
  - Exactly one an bit is active at any time after reset.
  - SEG_ACTIVE_LOW inverts both seg and an.
- Reset mid-operation: immediate return to reset values; no partial update survives. After deassert, counting resumes only after a fresh start_stop.

Test Plan:
- Reset then 3 tick_in rising edges, no start_stop -> digits stay 00:00, running=0; one cycle after deassert an=1110 and seg=1000000.
- start_stop, then 12 ticks -> running=1; sec_tens=1 and sec_ones=2; each update lands exactly 2 clk_in edges after tick_in is first sampled high.
- Preload via 3599 ticks, then one more tick -> 59:59 becomes 00:00; rollover high exactly 1 cycle; running stays 1.
- In RUN, start_stop on the tick cycle, then 5 ticks, then start_stop, then 2 ticks:
  - first tick counted, 5 ignored, then 2 counted;
  - total 00:03.
- clear and start_stop on the same cycle as a tick at 00:07 -> 00:00, IDLE, running=0; no increment.
- REFRESH_DIV=4: an cycles 1110, 1101, 1011, 0111 every 4 cycles. With 12:34 loaded, seg shows 4, 3, 2, 1 on the matching an, lagging the index by one cycle. rst pulse mid-scan -> an=1110 immediately.

Source files
------------

// File: rtl/stopwatch_if.sv
`timescale 1ns/1ps
// Control and display bundle between the board logic and stopwatch_core.
// master drives controls and reads results; slave is the stopwatch itself.
interface stopwatch_if;
  logic       tick_in;
  logic       start_stop;
  logic       clear;
  logic       running;
  logic       rollover;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic [6:0] seg;
  logic [3:0] an;

  modport master (
    output tick_in, start_stop, clear,
    input  running, rollover, sec_ones, sec_tens, min_ones, min_tens, seg, an
  );

  modport slave (
    input  tick_in, start_stop, clear,
    output running, rollover, sec_ones, sec_tens, min_ones, min_tens, seg, an
  );
endinterface

// File: rtl/stopwatch_core.sv
`timescale 1ns/1ps
// mm:ss BCD stopwatch driven by a 1 Hz square wave sampled as data on clk_in,
// with start/stop/clear control and a 4-digit multiplexed 7-segment driver.
module stopwatch_core #(
  parameter int REFRESH_DIV    = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk_in,
  input  logic        rst,
  stopwatch_if.slave  sw
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  localparam int                CNT_W        = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0]  REFRESH_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [6:0]        SEG_INV      = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0]        AN_INV       = SEG_ACTIVE_LOW ? 4'hF : 4'h0;

  state_t           state_q, state_d;
  logic             s1, s2, s2_d, tick, count_en;
  logic             running_q, roll_q;
  logic [3:0]       so_q, st_q, mo_q, mt_q;
  logic [CNT_W-1:0] refresh_q;
  logic [1:0]       idx_q;
  logic [3:0]       digit;
  logic [6:0]       seg_q;
  logic [3:0]       an_q;

  // Standard glyphs as {g,f,e,d,c,b,a}, active-high; non-BCD values blank.
  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'b0111111;
      4'd1:    glyph = 7'b0000110;
      4'd2:    glyph = 7'b1011011;
      4'd3:    glyph = 7'b1001111;
      4'd4:    glyph = 7'b1100110;
      4'd5:    glyph = 7'b1101101;
      4'd6:    glyph = 7'b1111101;
      4'd7:    glyph = 7'b0000111;
      4'd8:    glyph = 7'b1111111;
      4'd9:    glyph = 7'b1101111;
      default: glyph = 7'b0000000;
    endcase
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s2_d <= 1'b0;
    end else begin
      s1   <= sw.tick_in;
      s2   <= s1;
      s2_d <= s2;
    end
  end

  assign tick     = s2 & ~s2_d;
  assign count_en = tick && (state_q == RUN) && !sw.clear;

  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned and infers a latch.
    state_d = state_q;
    if (sw.clear) begin
      state_d = IDLE;
    end else if (sw.start_stop) begin
      case (state_q)
        RUN:     state_d = PAUSE;
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == RUN);
    end
  end

  // Ripple BCD carry chain; rollover pulses only on the 59:59 -> 00:00 step.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      so_q   <= 4'd0;
      st_q   <= 4'd0;
      mo_q   <= 4'd0;
      mt_q   <= 4'd0;
      roll_q <= 1'b0;
    end else begin
      roll_q <= 1'b0;
      if (sw.clear) begin
        so_q <= 4'd0;
        st_q <= 4'd0;
        mo_q <= 4'd0;
        mt_q <= 4'd0;
      end else if (count_en) begin
        if (so_q == 4'd9) begin
          so_q <= 4'd0;
          if (st_q == 4'd5) begin
            st_q <= 4'd0;
            if (mo_q == 4'd9) begin
              mo_q <= 4'd0;
              if (mt_q == 4'd5) begin
                mt_q   <= 4'd0;
                roll_q <= 1'b1;
              end else begin
                mt_q <= mt_q + 4'd1;
              end
            end else begin
              mo_q <= mo_q + 4'd1;
            end
          end else begin
            st_q <= st_q + 4'd1;
          end
        end else begin
          so_q <= so_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      refresh_q <= '0;
      idx_q     <= 2'd0;
    end else if (refresh_q == REFRESH_LAST) begin
      refresh_q <= '0;
      idx_q     <= idx_q + 2'd1;
    end else begin
      refresh_q <= refresh_q + CNT_W'(1);
    end
  end

  always_comb begin
    digit = so_q;
    case (idx_q)
      2'd0: digit = so_q;
      2'd1: digit = st_q;
      2'd2: digit = mo_q;
      2'd3: digit = mt_q;
    endcase
  end

  // Registered drive: seg/an trail the index and digit values by one cycle.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      seg_q <= glyph(4'd0) ^ SEG_INV;
      an_q  <= 4'b0001 ^ AN_INV;
    end else begin
      seg_q <= glyph(digit) ^ SEG_INV;
      an_q  <= (4'b0001 << idx_q) ^ AN_INV;
    end
  end

  assign sw.running  = running_q;
  assign sw.rollover = roll_q;
  assign sw.sec_ones = so_q;
  assign sw.sec_tens = st_q;
  assign sw.min_ones = mo_q;
  assign sw.min_tens = mt_q;
  assign sw.seg      = seg_q;
  assign sw.an       = an_q;

endmodule

// File: tb/tb_stopwatch_core.sv
`timescale 1ns/1ps
// Bench for stopwatch_core: stimulus pushes expected state changes (with the
// cycle they must appear) into a queue; a monitor pops on every observed change.
module tb_stopwatch_core;

  logic clk_in = 1'b0;
  logic rst;
  always #10 clk_in = ~clk_in;

  stopwatch_if sw ();

  stopwatch_core #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .sw     (sw)
  );

  typedef struct packed {
    logic       running;
    logic       rollover;
    logic [3:0] mt, mo, st, so;
  } obs_t;

  typedef struct {
    obs_t o;
    int   cyc;
  } exp_t;

  typedef enum {M_IDLE, M_RUN, M_PAUSE} mstate_t;

  exp_t    sb_q[$];
  int      n_vec = 0;
  int      n_err = 0;
  int      cyc = 0;
  bit      mon_en = 1'b0;
  mstate_t m_st;
  int      m_secs;
  obs_t    m_prev;
  obs_t    prev_obs;

  always @(posedge clk_in) cyc <= cyc + 1;

  function automatic obs_t dut_obs();
    return {sw.running, sw.rollover, sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones};
  endfunction

  // Model keeps elapsed seconds as an integer and derives BCD digits from it.
  function automatic obs_t model_obs(input bit roll);
    obs_t o;
    o.running  = (m_st == M_RUN);
    o.rollover = roll;
    o.so       = 4'(m_secs % 10);
    o.st       = 4'((m_secs % 60) / 10);
    o.mo       = 4'((m_secs / 60) % 10);
    o.mt       = 4'(m_secs / 600);
    return o;
  endfunction

  task automatic expect_obs(input obs_t o, input int at);
    if (o != m_prev) begin
      sb_q.push_back('{o, at});
      m_prev = o;
    end
  endtask

  task automatic model_step(input bit tk, input bit ss, input bit clr, input int at);
    bit roll;
    roll = 1'b0;
    if (clr) begin
      m_secs = 0;
      m_st   = M_IDLE;
    end else begin
      if (tk && m_st == M_RUN) begin
        roll   = (m_secs == 3599);
        m_secs = (m_secs + 1) % 3600;
      end
      if (ss) begin
        case (m_st)
          M_IDLE:  m_st = M_RUN;
          M_RUN:   m_st = M_PAUSE;
          default: m_st = M_RUN;
        endcase
      end
    end
    expect_obs(model_obs(roll), at);
    if (roll) expect_obs(model_obs(1'b0), at + 1);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // One control pulse, sampled at the next edge; visible one cycle later.
  task automatic pulse(input bit ss, input bit clr);
    @(negedge clk_in);
    sw.start_stop = ss;
    sw.clear      = clr;
    model_step(1'b0, ss, clr, cyc + 1);
    @(negedge clk_in);
    sw.start_stop = 1'b0;
    sw.clear      = 1'b0;
  endtask

  // tick_in first sampled at edge k (cyc becomes c+1); update at edge k+2 (c+3).
  // Optional control pulse lands on that same update edge.
  task automatic do_tick(input bit ss, input bit clr);
    int c;
    @(negedge clk_in);
    sw.tick_in = 1'b1;
    c = cyc;
    @(negedge clk_in);
    @(negedge clk_in);
    sw.tick_in    = 1'b0;
    sw.start_stop = ss;
    sw.clear      = clr;
    model_step(1'b1, ss, clr, c + 3);
    @(negedge clk_in);
    sw.start_stop = 1'b0;
    sw.clear      = 1'b0;
    @(negedge clk_in);
  endtask

  always @(negedge clk_in) begin
    obs_t cur;
    exp_t e;
    cur = dut_obs();
    if (mon_en && cur != prev_obs) begin
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_change got=%h at cyc %0d", cur, cyc);
      end else begin
        e = sb_q.pop_front();
        if (cur != e.o || cyc != e.cyc) begin
          n_err++;
          $display("FAIL sb_update got=%h@%0d want=%h@%0d", cur, cyc, e.o, e.cyc);
        end
      end
    end
    prev_obs = cur;
  end

  logic [3:0] an_exp  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] seg_exp [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};

  initial begin
    sw.tick_in    = 1'b0;
    sw.start_stop = 1'b0;
    sw.clear      = 1'b0;
    rst           = 1'b1;
    m_st          = M_IDLE;
    m_secs        = 0;
    m_prev        = model_obs(1'b0);

    repeat (3) @(negedge clk_in);
    check("rst_running", 32'(sw.running), 32'd0);
    check("rst_rollover", 32'(sw.rollover), 32'd0);
    check("rst_digits", {16'd0, sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones}, 32'h0);
    check("rst_an", 32'(sw.an), 32'b1110);
    check("rst_seg", 32'(sw.seg), 32'b1000000);
    rst = 1'b0;
    @(negedge clk_in);
    check("post_rst_an", 32'(sw.an), 32'b1110);
    check("post_rst_seg", 32'(sw.seg), 32'b1000000);
    mon_en = 1'b1;

    // Ticks in IDLE are ignored.
    repeat (3) do_tick(1'b0, 1'b0);
    check("idle_digits", {16'd0, sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones}, 32'h0);
    check("idle_running", 32'(sw.running), 32'd0);

    // Run and count 12 seconds.
    pulse(1'b1, 1'b0);
    repeat (12) do_tick(1'b0, 1'b0);
    check("run12_running", 32'(sw.running), 32'd1);
    check("run12_digits", {16'd0, sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones}, 32'h0012);

    // Full-range count to 59:59 then wrap.
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    repeat (3599) do_tick(1'b0, 1'b0);
    check("preload_5959", {16'd0, sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones}, 32'h5959);
    do_tick(1'b0, 1'b0);
    check("wrap_digits", {16'd0, sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones}, 32'h0);
    check("wrap_running", 32'(sw.running), 32'd1);

    // Pause on a tick cycle, ignored ticks, resume.
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    do_tick(1'b1, 1'b0);
    check("pause_running", 32'(sw.running), 32'd0);
    repeat (5) do_tick(1'b0, 1'b0);
    pulse(1'b1, 1'b0);
    repeat (2) do_tick(1'b0, 1'b0);
    check("resume_digits", {16'd0, sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones}, 32'h0003);

    // clear + start_stop + tick together at 00:07.
    repeat (4) do_tick(1'b0, 1'b0);
    check("at_0007", {16'd0, sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones}, 32'h0007);
    do_tick(1'b1, 1'b1);
    check("clr_digits", {16'd0, sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones}, 32'h0);
    check("clr_running", 32'(sw.running), 32'd0);

    // Load 12:34, pause, then watch the display scan.
    pulse(1'b1, 1'b0);
    repeat (754) do_tick(1'b0, 1'b0);
    pulse(1'b1, 1'b0);
    check("load_1234", {16'd0, sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones}, 32'h1234);
    for (int k = 0; k < 20 && sw.an != 4'b0111; k++) @(negedge clk_in);
    for (int k = 0; k < 10 && sw.an != 4'b1110; k++) @(negedge clk_in);
    check("scan_sync", 32'(sw.an), 32'b1110);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("scan_an_%0d", i), 32'(sw.an), 32'(an_exp[i/4]));
      check($sformatf("scan_seg_%0d", i), 32'(sw.seg), 32'(seg_exp[i/4]));
      @(negedge clk_in);
    end

    // Reset mid-scan returns to the reset image at once.
    repeat (5) @(negedge clk_in);
    check("pre_rst_an", 32'(sw.an), 32'b1101);
    mon_en = 1'b0;
    rst    = 1'b1;
    #1;
    check("midrst_an", 32'(sw.an), 32'b1110);
    check("midrst_seg", 32'(sw.seg), 32'b1000000);
    check("midrst_digits", {16'd0, sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones}, 32'h0);
    check("midrst_running", 32'(sw.running), 32'd0);
    m_st   = M_IDLE;
    m_secs = 0;
    m_prev = model_obs(1'b0);
    @(negedge clk_in);
    rst = 1'b0;
    @(negedge clk_in);
    mon_en = 1'b1;
    repeat (2) do_tick(1'b0, 1'b0);
    check("post_midrst_digits", {16'd0, sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones}, 32'h0);
    check("post_midrst_running", 32'(sw.running), 32'd0);

    for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(negedge clk_in);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
